// File: rtl/risc_lsu.sv
// risc_lsu: single-outstanding load/store unit between the execute stage and a word-wide memory port.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module risc_lsu #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_REQ    = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

  logic [1:0]  state_r;
  logic [31:0] wait_cnt_r;
  logic [1:0]  ld_size_r;
  logic        ld_unsigned_r;
  logic [1:0]  ld_shift_r;

  logic        is_byte_s;
  logic        is_half_s;
  logic [1:0]  lo_s;
  logic        misalign_s;
  logic [3:0]  strb_s;
  logic [31:0] wdata_rep_s;
  logic        timeout_hit_s;
  logic        accept_s;

  function automatic logic [31:0] extend_load(
    input logic [31:0] rdata,
    input logic [1:0]  shift,
    input logic [1:0]  size,
    input logic        zext
  );
    logic [31:0] lane;
    lane = rdata >> {shift, 3'b000};
    case (size)
      2'b00:   extend_load = zext ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   extend_load = zext ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: extend_load = lane;
    endcase
  endfunction

  assign req_ready     = (state_r == S_IDLE) && !rst;
  assign accept_s      = req_valid && req_ready;
  assign timeout_hit_s = (TO_LIMIT != 32'd0) && ((wait_cnt_r + 32'd1) == TO_LIMIT);

  // Request decode: aligned lane offset, byte strobes and lane-replicated store data.
  always_comb begin
    is_byte_s = (req_size == 2'b00);
    is_half_s = (req_size == 2'b01);
    if (is_byte_s) begin
      lo_s = addr[1:0];
    end else if (is_half_s) begin
      lo_s = {addr[1], 1'b0};
    end else begin
      lo_s = 2'b00;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_s = (is_half_s && addr[0]) ||
                 (!is_byte_s && !is_half_s && (addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    case (req_size)
      2'b00: begin
        strb_s      = 4'b0001 << lo_s;
        wdata_rep_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_s      = lo_s[1] ? 4'b1100 : 4'b0011;
        wdata_rep_s = {2{wdata[15:0]}};
      end
      default: begin
        strb_s      = 4'b1111;
        wdata_rep_s = wdata;
      end
    endcase
  end

  // Access sequencer: IDLE -> REQ (hold memory request) -> RESP (one-cycle response) -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      wait_cnt_r    <= 32'd0;
      ld_size_r     <= 2'b00;
      ld_unsigned_r <= 1'b0;
      ld_shift_r    <= 2'b00;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wstrb     <= 4'b0000;
      mem_wdata     <= 32'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_fault     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s && misalign_s) begin
            state_r   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= 32'd0;
          end else if (accept_s) begin
            state_r       <= S_REQ;
            wait_cnt_r    <= 32'd0;
            mem_req       <= 1'b1;
            mem_we        <= req_we;
            mem_addr      <= {addr[31:2], 2'b00};
            mem_wstrb     <= req_we ? strb_s : 4'b0000;
            mem_wdata     <= req_we ? wdata_rep_s : 32'd0;
            ld_size_r     <= req_size;
            ld_unsigned_r <= req_unsigned;
            ld_shift_r    <= lo_s;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          // An ack in the same cycle the timeout expires still completes normally.
          if (mem_ack || timeout_hit_s) begin
            state_r   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= !mem_ack;
            if (mem_ack && !mem_we) begin
              rsp_rdata <= extend_load(mem_rdata, ld_shift_r, ld_size_r, ld_unsigned_r);
            end else begin
              rsp_rdata <= 32'd0;
            end
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'd0;
            wait_cnt_r <= 32'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        S_RESP: begin
          state_r   <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: begin
          state_r   <= S_IDLE;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule
